// File: rtl/axi_uart_lite_slave.sv
// AXI4-lite register front end for an 8N1 UART: RX/TX FIFOs, status/control registers
// and a fixed-baud serial transmitter/receiver pair.
`timescale 1ns/1ps
module axi_uart_lite_slave #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uart_axi_araddr,
  input  logic        uart_axi_arvalid,
  output logic        uart_axi_arready,
  output logic [31:0] uart_axi_rdata,
  output logic [1:0]  uart_axi_rresp,
  output logic        uart_axi_rvalid,
  input  logic        uart_axi_rready,
  input  logic [3:0]  uart_axi_awaddr,
  input  logic        uart_axi_awvalid,
  output logic        uart_axi_awready,
  input  logic [31:0] uart_axi_wdata,
  input  logic [3:0]  uart_axi_wstrb,
  input  logic        uart_axi_wvalid,
  output logic        uart_axi_wready,
  output logic [1:0]  uart_axi_bresp,
  output logic        uart_axi_bvalid,
  input  logic        uart_axi_bready,
  output logic        txd,
  input  logic        rxd
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CPB_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CPB_MID  = CW'(CPB / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  r_state_t  r_state, r_next;
  w_state_t  w_state, w_next;
  rx_state_t rx_state, rx_next;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_load, tx_flush, rx_push, rx_pop, rx_flush;
  logic        rd_fire, wr_fire;
  logic [1:0]  rsel, wsel;
  logic        ie, overrun, frame_err;
  logic [7:0]  stat;

  logic          tx_busy, tx_tick;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_sh;

  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick, rx_mid, rx_stop_tick, rx_ferr, rx_good, rx_overrun;

  logic unused_inputs;
  assign unused_inputs = ^{uart_axi_wstrb, uart_axi_araddr[1:0], uart_axi_awaddr[1:0],
                           uart_axi_wdata[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= R_IDLE;
      w_state  <= W_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      r_state  <= r_next;
      w_state  <= w_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    r_next           = r_state;
    uart_axi_arready = 1'b0;
    uart_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE:  if (uart_axi_arvalid) r_next = R_ACK;
      R_ACK:   begin uart_axi_arready = 1'b1; r_next = R_DATA; end
      R_DATA:  begin uart_axi_rvalid = 1'b1; if (uart_axi_rready) r_next = R_IDLE; end
      default: r_next = R_IDLE;
    endcase
  end

  // Address and data are taken together; AW is never accepted on its own.
  always_comb begin
    w_next           = w_state;
    uart_axi_awready = 1'b0;
    uart_axi_wready  = 1'b0;
    uart_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE:  if (uart_axi_awvalid && uart_axi_wvalid) w_next = W_ACK;
      W_ACK:   begin uart_axi_awready = 1'b1; uart_axi_wready = 1'b1; w_next = W_RESP; end
      W_RESP:  begin uart_axi_bvalid = 1'b1; if (uart_axi_bready) w_next = W_IDLE; end
      default: w_next = W_IDLE;
    endcase
  end

  assign rd_fire  = (r_state == R_ACK);
  assign wr_fire  = (w_state == W_ACK);
  assign rsel     = uart_axi_araddr[3:2];
  assign wsel     = uart_axi_awaddr[3:2];
  assign tx_empty = (tx_wp == tx_rp);
  assign rx_empty = (rx_wp == rx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_pop   = rd_fire && (rsel == 2'd0) && !rx_empty;
  assign tx_push  = wr_fire && (wsel == 2'd1) && (!tx_full || tx_load);
  assign tx_flush = wr_fire && (wsel == 2'd3) && uart_axi_wdata[0];
  assign rx_flush = wr_fire && (wsel == 2'd3) && uart_axi_wdata[1];
  assign stat     = {1'b0, frame_err, overrun, ie, tx_full, tx_empty, rx_full, !rx_empty};

  // Response registers; sticky error flags set after a STAT read clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_axi_rdata <= 32'h0;
      uart_axi_rresp <= 2'b00;
      uart_axi_bresp <= 2'b00;
      ie             <= 1'b0;
      overrun        <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      if (rd_fire) begin
        uart_axi_rdata <= 32'h0;
        uart_axi_rresp <= 2'b00;
        case (rsel)
          2'd0: if (rx_empty) uart_axi_rresp <= 2'b10;
                else uart_axi_rdata <= {24'h0, rx_mem[rx_rp[AW-1:0]]};
          2'd2: uart_axi_rdata <= {24'h0, stat};
          default: ;
        endcase
        if (rsel == 2'd2) begin
          overrun   <= 1'b0;
          frame_err <= 1'b0;
        end
      end
      if (wr_fire) begin
        uart_axi_bresp <= ((wsel == 2'd1) && !tx_push) ? 2'b10 : 2'b00;
        if (wsel == 2'd3) ie <= uart_axi_wdata[4];
      end
      if (rx_overrun) overrun   <= 1'b1;
      if (rx_ferr)    frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + 1'b1;
        if (tx_load) tx_rp <= tx_rp + 1'b1;
      end
      if (rx_flush) begin
        rx_wp <= '0;
        rx_rp <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + 1'b1;
        if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= uart_axi_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // Transmitter: a new frame may load on the same edge the previous stop bit ends.
  assign tx_tick = tx_busy && (tx_cnt == CPB_LAST);
  assign tx_load = !tx_empty && (!tx_busy || (tx_tick && (tx_bit == 4'd9)));
  assign txd     = tx_sh[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= {1'b1, tx_mem[tx_rp[AW-1:0]], 1'b0};
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else tx_bit <= tx_bit + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // Receiver: start is re-checked at mid-bit, every later sample lands on a bit centre.
  assign rx_tick      = (rx_cnt == CPB_LAST);
  assign rx_mid       = (rx_cnt == CPB_MID);
  assign rx_stop_tick = (rx_state == RX_STOP) && rx_tick;
  assign rx_ferr      = rx_stop_tick && !rx_s2;
  assign rx_good      = rx_stop_tick && rx_s2;
  assign rx_push      = rx_good && (!rx_full || rx_pop);
  assign rx_overrun   = rx_good && rx_full && !rx_pop;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
        RX_START: rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
        default: begin
          rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
          if ((rx_state == RX_DATA) && rx_tick) rx_bit <= rx_bit + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((rx_state == RX_DATA) && rx_tick) rx_sh <= {rx_s2, rx_sh[7:1]};
  end

endmodule
